// File: rtl/cpu_clk_sync_top.sv
// Clock/reset entry block for the CPU: divide-by-2 enable, synchronized reset,
// data synchronizer and LED debug capture (enabled by PCDEBUG_CAPTURE_EN).
module cpu_clk_sync_top #(
    parameter int LEN    = 1,
    parameter int STAGES = 2
) (
    input  logic            sysClk,
    input  logic            sysRes,
    input  logic [LEN-1:0]  dataIn,
    output logic [LEN-1:0]  dataOut,
    output logic            clkDiv2,
    output logic            resSync,
    input  logic [31:0]     dbgIn,
    output logic [15:0]     PCdebug
);

    logic [LEN-1:0]    dataChain [STAGES];
    logic [STAGES-1:0] resChain;
    logic              div2;

    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            div2 <= 1'b0;
        end else begin
            div2 <= ~div2;
        end
    end

    // Each bit is synchronized on its own; no multi-bit coherency.
    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            for (int k = 0; k < STAGES; k++) begin
                dataChain[k] <= '0;
            end
        end else begin
            dataChain[0] <= dataIn;
            for (int k = 1; k < STAGES; k++) begin
                dataChain[k] <= dataChain[k-1];
            end
        end
    end

    // Asserts asynchronously; the zero shifted in releases it STAGES edges later.
    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            resChain <= '1;
        end else begin
            resChain <= {resChain[STAGES-2:0], 1'b0};
        end
    end

    assign clkDiv2 = div2;
    assign dataOut = dataChain[STAGES-1];
    assign resSync = resChain[STAGES-1];

`ifdef PCDEBUG_CAPTURE_EN
    logic [15:0] pcReg;

    // Capture once per CPU cycle, only after the CPU has left reset.
    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            pcReg <= '0;
        end else if (div2 && !resSync) begin
            pcReg <= dbgIn[31:16];
        end
    end

    assign PCdebug = pcReg;
`else
    logic unused_dbg;

    assign unused_dbg = ^dbgIn;
    assign PCdebug    = '0;
`endif

endmodule

// File: tb/tb_cpu_clk_sync_top.sv
// Directed bench for cpu_clk_sync_top: a STAGES=2 and a STAGES=3 instance
// share clock, reset and inputs; expectations are hand-derived per edge.
module tb_cpu_clk_sync_top;

`ifdef PCDEBUG_CAPTURE_EN
    localparam bit PC_ON = 1'b1;
`else
    localparam bit PC_ON = 1'b0;
`endif

    logic        sysClk = 1'b0;
    logic        sysRes;
    logic [3:0]  dataIn;
    logic [31:0] dbgIn;

    logic [3:0]  dataOut2, dataOut3;
    logic        clkDiv2_2, clkDiv2_3;
    logic        resSync2, resSync3;
    logic [15:0] pc2, pc3;

    int checks = 0;
    int errors = 0;

    always #5 sysClk = ~sysClk;

    cpu_clk_sync_top #(.LEN(4), .STAGES(2)) dut2 (
        .sysClk (sysClk),
        .sysRes (sysRes),
        .dataIn (dataIn),
        .dataOut(dataOut2),
        .clkDiv2(clkDiv2_2),
        .resSync(resSync2),
        .dbgIn  (dbgIn),
        .PCdebug(pc2)
    );

    cpu_clk_sync_top #(.LEN(4), .STAGES(3)) dut3 (
        .sysClk (sysClk),
        .sysRes (sysRes),
        .dataIn (dataIn),
        .dataOut(dataOut3),
        .clkDiv2(clkDiv2_3),
        .resSync(resSync3),
        .dbgIn  (dbgIn),
        .PCdebug(pc3)
    );

    typedef struct {
        logic [3:0]  din;
        logic [31:0] dbg;
        logic        clk;
        logic        rs2;
        logic        rs3;
        logic [3:0]  do2;
        logic [3:0]  do3;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge sysClk);
        #1;
    endtask

    function automatic logic [15:0] pc_exp(input logic [15:0] v);
        return PC_ON ? v : 16'h0000;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " clkDiv2_2"}, 32'(clkDiv2_2), 32'd0);
        check({tag, " clkDiv2_3"}, 32'(clkDiv2_3), 32'd0);
        check({tag, " resSync2"},  32'(resSync2),  32'd1);
        check({tag, " resSync3"},  32'(resSync3),  32'd1);
        check({tag, " dataOut2"},  32'(dataOut2),  32'd0);
        check({tag, " dataOut3"},  32'(dataOut3),  32'd0);
        check({tag, " pc2"},       32'(pc2),       32'd0);
        check({tag, " pc3"},       32'(pc3),       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Edge-by-edge table after reset release (dataIn/dbgIn applied before the edge).
        vecs[0] = '{4'hA, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 16'h0000};
        vecs[1] = '{4'hA, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 4'hA, 4'h0, 16'h0000};
        vecs[2] = '{4'hA, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 4'hA, 4'hA, 16'h0000};
        vecs[3] = '{4'hA, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 16'hDEAD};
        vecs[4] = '{4'h5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 4'hA, 4'hA, 16'hDEAD};
        vecs[5] = '{4'h5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 4'h5, 4'hA, 16'hDEAD};
        vecs[6] = '{4'h5, 32'h1234_0000, 1'b1, 1'b0, 1'b0, 4'h5, 4'h5, 16'hDEAD};
        vecs[7] = '{4'h5, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 4'h5, 4'h5, 16'h1234};
        vecs[8] = '{4'h5, 32'h1234_0000, 1'b1, 1'b0, 1'b0, 4'h5, 4'h5, 16'h1234};
        vecs[9] = '{4'h5, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 4'h5, 4'h5, 16'h1234};

        sysRes = 1'b1;
        dataIn = 4'h0;
        dbgIn  = 32'hFFFF_FFFF;
        #2;
        check_reset_state("por");
        for (int i = 0; i < 3; i++) step_edge();
        check_reset_state("held");

        // Release just after an edge; table drives the following 10 edges.
        sysRes = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dataIn = vecs[i].din;
            dbgIn  = vecs[i].dbg;
            check($sformatf("release e%0d resSync2 hold", i), 32'(resSync2), 32'(i == 0 ? 1 : vecs[i-1].rs2));
            step_edge();
            check($sformatf("e%0d clkDiv2_2", i + 1), 32'(clkDiv2_2), 32'(vecs[i].clk));
            check($sformatf("e%0d clkDiv2_3", i + 1), 32'(clkDiv2_3), 32'(vecs[i].clk));
            check($sformatf("e%0d resSync2", i + 1),  32'(resSync2),  32'(vecs[i].rs2));
            check($sformatf("e%0d resSync3", i + 1),  32'(resSync3),  32'(vecs[i].rs3));
            check($sformatf("e%0d dataOut2", i + 1),  32'(dataOut2),  32'(vecs[i].do2));
            check($sformatf("e%0d dataOut3", i + 1),  32'(dataOut3),  32'(vecs[i].do3));
            check($sformatf("e%0d pc2", i + 1),       32'(pc2),       32'(pc_exp(vecs[i].pc)));
            check($sformatf("e%0d pc3", i + 1),       32'(pc3),       32'(pc_exp(vecs[i].pc)));
        end

        // Asynchronous reset between edges: outputs clear with no clock edge.
        #2;
        sysRes = 1'b1;
        #1;
        check_reset_state("async");
        step_edge();
        check_reset_state("async edge");
        sysRes = 1'b0;
        step_edge();
        check("r1 clkDiv2_2", 32'(clkDiv2_2), 32'd1);
        check("r1 resSync2",  32'(resSync2),  32'd1);
        check("r1 dataOut2",  32'(dataOut2),  32'h0);
        step_edge();
        check("r2 clkDiv2_2", 32'(clkDiv2_2), 32'd0);
        check("r2 resSync2",  32'(resSync2),  32'd0);
        check("r2 resSync3",  32'(resSync3),  32'd1);
        check("r2 dataOut2",  32'(dataOut2),  32'h5);
        step_edge();
        check("r3 resSync3",  32'(resSync3),  32'd0);
        check("r3 dataOut3",  32'(dataOut3),  32'h5);
        check("r3 pc2",       32'(pc2),       32'h0);
        step_edge();
        check("r4 pc2", 32'(pc2), 32'(pc_exp(16'h1234)));
        check("r4 pc3", 32'(pc3), 32'(pc_exp(16'h1234)));

        // Countdown restart: 1 ns pulse one edge after release.
        sysRes = 1'b1;
        step_edge();
        sysRes = 1'b0;
        step_edge();
        check("c1 resSync2", 32'(resSync2), 32'd1);
        #2;
        sysRes = 1'b1;
        #1;
        check("pulse resSync2", 32'(resSync2),  32'd1);
        check("pulse resSync3", 32'(resSync3),  32'd1);
        check("pulse clkDiv2",  32'(clkDiv2_2), 32'd0);
        sysRes = 1'b0;
        step_edge();
        check("p1 resSync2", 32'(resSync2), 32'd1);
        step_edge();
        check("p2 resSync2", 32'(resSync2), 32'd0);
        check("p2 resSync3", 32'(resSync3), 32'd1);
        step_edge();
        check("p3 resSync3", 32'(resSync3), 32'd0);
        check("p3 pc2",      32'(pc2),      32'h0);

        // All-ones debug word: captured only in the capture build.
        dbgIn = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            step_edge();
            check($sformatf("ones e%0d pc2", i), 32'(pc2), 32'(pc_exp(16'hFFFF)));
            check($sformatf("ones e%0d pc3", i), 32'(pc3), 32'(pc_exp(16'hFFFF)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
